// File: rtl/i2c_target_model.sv
// i2c_target_model
//   I2C target (device) model with an EEPROM-style byte register file and an
//   auto-incrementing pointer. A write transaction sets the pointer with its
//   first data byte and stores the following bytes; a read transaction
//   streams registers starting at the pointer. SDA is driven open-drain
//   through sda_oe_o only, and SCL is never stretched.
//
// Parameters
//   TargetAddr : 7-bit bus address this device answers to
//   NumRegs    : number of 8-bit registers (power of two, 2..256)
//   PtrW       : pointer width, derived from NumRegs (leave at default)
//
// Ports
//   clk_i      : system clock, at least 8x the SCL frequency
//   rst_ni     : asynchronous active-low reset
//   scl_i      : resolved bus SCL (asynchronous)
//   sda_i      : resolved bus SDA (asynchronous)
//   sda_oe_o   : 1 = pull SDA low, 0 = release
//   wr_valid_o : one-cycle pulse per register write
//   wr_addr_o  : index of the register written
//   wr_data_o  : byte written
//   bk_addr_i  : backdoor read index
//   bk_data_o  : combinational regs[bk_addr_i]
module i2c_target_model #(
    parameter logic [6:0]  TargetAddr = 7'h50,
    parameter int unsigned NumRegs    = 16,
    parameter int unsigned PtrW       = $clog2(NumRegs)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            scl_i,
    input  logic            sda_i,
    output logic            sda_oe_o,
    output logic            wr_valid_o,
    output logic [PtrW-1:0] wr_addr_o,
    output logic [7:0]      wr_data_o,
    input  logic [PtrW-1:0] bk_addr_i,
    output logic [7:0]      bk_data_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_ACK,
        S_WAIT_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers plus one history flop per line. They reset to
    // the idle bus level so that reset release never looks like an edge.
    // ------------------------------------------------------------------
    logic r_scl_s1, r_scl_s2, r_scl_h;
    logic r_sda_s1, r_sda_s2, r_sda_h;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_h  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_h  <= 1'b1;
        end else begin
            r_scl_s1 <= scl_i;
            r_scl_s2 <= r_scl_s1;
            r_scl_h  <= r_scl_s2;
            r_sda_s1 <= sda_i;
            r_sda_s2 <= r_sda_s1;
            r_sda_h  <= r_sda_s2;
        end
    end

    logic w_scl_rise, w_scl_fall, w_start, w_stop;

    assign w_scl_rise = r_scl_s2 & ~r_scl_h;
    assign w_scl_fall = ~r_scl_s2 & r_scl_h;
    // SDA edges only count as START/STOP while SCL is steadily high.
    assign w_start    = r_scl_s2 & r_scl_h & r_sda_h & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_h & ~r_sda_h & r_sda_s2;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t          r_state, w_state_d;
    logic [2:0]      r_cnt, w_cnt_d;
    // Seven bits suffice in both directions: on receive the eighth bit is
    // the live SDA sample, on transmit bit 7 is already on the bus at load.
    logic [6:0]      r_shift, w_shift_d;
    // Second half of the current state's work: ACK being driven in the
    // target-ACK states, last bit sent in RDATA, controller ACK seen in
    // RDATA_ACK.
    logic            r_phase, w_phase_d;
    logic            r_rw, w_rw_d;
    logic [PtrW-1:0] r_ptr, w_ptr_d;
    logic            r_sda_oe, w_sda_oe_d;
    logic            w_we;

    logic [7:0]      r_regs [NumRegs];
    logic            r_wr_valid;
    logic [PtrW-1:0] r_wr_addr;
    logic [7:0]      r_wr_data;

    logic [7:0]      w_rx_byte;
    logic [7:0]      w_rd_byte;

    assign w_rx_byte = {r_shift, r_sda_s2};
    assign w_rd_byte = r_regs[r_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_phase  <= 1'b0;
            r_rw     <= 1'b0;
            r_ptr    <= '0;
            r_sda_oe <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_shift  <= w_shift_d;
            r_phase  <= w_phase_d;
            r_rw     <= w_rw_d;
            r_ptr    <= w_ptr_d;
            r_sda_oe <= w_sda_oe_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_shift_d  = r_shift;
        w_phase_d  = r_phase;
        w_rw_d     = r_rw;
        w_ptr_d    = r_ptr;
        w_sda_oe_d = r_sda_oe;
        w_we       = 1'b0;

        if (w_stop) begin
            w_state_d  = S_IDLE;
            w_phase_d  = 1'b0;
            w_sda_oe_d = 1'b0;
        end else if (w_start) begin
            w_state_d  = S_ADDR;
            w_cnt_d    = '0;
            w_phase_d  = 1'b0;
            w_sda_oe_d = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_WAIT_STOP: begin
                    // Only START/STOP move us out of here.
                end

                S_ADDR, S_PTR, S_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_d = w_rx_byte[6:0];
                        w_cnt_d   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_phase_d = 1'b0;
                            if (r_state == S_ADDR) begin
                                if (w_rx_byte[7:1] == TargetAddr) begin
                                    w_rw_d    = w_rx_byte[0];
                                    w_state_d = S_ADDR_ACK;
                                end else begin
                                    w_state_d = S_WAIT_STOP;
                                end
                            end else if (r_state == S_PTR) begin
                                w_ptr_d   = w_rx_byte[PtrW-1:0];
                                w_state_d = S_PTR_ACK;
                            end else begin
                                w_we      = 1'b1;
                                w_ptr_d   = r_ptr + PtrW'(1);
                                w_state_d = S_WDATA_ACK;
                            end
                        end
                    end
                end

                S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_phase) begin
                            w_sda_oe_d = 1'b1;
                            w_phase_d  = 1'b1;
                        end else begin
                            w_sda_oe_d = 1'b0;
                            w_phase_d  = 1'b0;
                            w_cnt_d    = '0;
                            if (r_state == S_ADDR_ACK && r_rw) begin
                                // Read: first data bit replaces the ACK on
                                // the same falling edge.
                                w_state_d  = S_RDATA;
                                w_shift_d  = w_rd_byte[6:0];
                                w_sda_oe_d = ~w_rd_byte[7];
                            end else if (r_state == S_ADDR_ACK) begin
                                w_state_d = S_PTR;
                            end else begin
                                w_state_d = S_WDATA;
                            end
                        end
                    end
                end

                S_RDATA: begin
                    if (w_scl_rise) begin
                        w_cnt_d = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_phase_d = 1'b1;
                        end
                    end else if (w_scl_fall) begin
                        if (r_phase) begin
                            w_sda_oe_d = 1'b0;
                            w_phase_d  = 1'b0;
                            w_state_d  = S_RDATA_ACK;
                        end else begin
                            w_sda_oe_d = ~r_shift[6];
                            w_shift_d  = {r_shift[5:0], 1'b0};
                        end
                    end
                end

                S_RDATA_ACK: begin
                    if (w_scl_rise) begin
                        w_ptr_d = r_ptr + PtrW'(1);
                        if (!r_sda_s2) begin
                            w_phase_d = 1'b1;
                        end else begin
                            w_state_d = S_WAIT_STOP;
                        end
                    end else if (w_scl_fall && r_phase) begin
                        w_state_d  = S_RDATA;
                        w_phase_d  = 1'b0;
                        w_cnt_d    = '0;
                        w_shift_d  = w_rd_byte[6:0];
                        w_sda_oe_d = ~w_rd_byte[7];
                    end
                end

                default: begin
                    w_state_d  = S_IDLE;
                    w_sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register file and write notification
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[r_ptr] <= w_rx_byte;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_valid <= w_we;
            if (w_we) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= w_rx_byte;
            end
        end
    end

    assign sda_oe_o   = r_sda_oe;
    assign wr_valid_o = r_wr_valid;
    assign wr_addr_o  = r_wr_addr;
    assign wr_data_o  = r_wr_data;
    assign bk_data_o  = r_regs[bk_addr_i];

endmodule

// File: tb/tb_i2c_target_model.sv
// Testbench for i2c_target_model: acts as the I2C controller, resolving the
// open-drain SDA line, and checks the device against a transaction-level
// model of the register file and pointer.
`timescale 1ns/1ps
module tb_i2c_target_model;

    localparam int         Q  = 50;      // quarter SCL period (5 clk)
    localparam logic [6:0] TA = 7'h50;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, scl_c, sda_c;
    logic       sda_oe, wr_valid;
    logic [3:0] wr_addr, bk_addr;
    logic [7:0] wr_data, bk_data;
    logic       sda_bus;

    assign sda_bus = sda_c & ~sda_oe;

    i2c_target_model #(
        .TargetAddr (7'h50),
        .NumRegs    (16)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .scl_i      (scl_c),
        .sda_i      (sda_bus),
        .sda_oe_o   (sda_oe),
        .wr_valid_o (wr_valid),
        .wr_addr_o  (wr_addr),
        .wr_data_o  (wr_data),
        .bk_addr_i  (bk_addr),
        .bk_data_o  (bk_data)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  m_regs [16];
    int          m_ptr;
    logic [11:0] act_q [$];
    logic [11:0] exp_q [$];
    int          oe_hi_cnt = 0;
    int          glitches = 0;
    logic        prev_oe = 1'b0;
    logic [7:0]  tx_buf [8];

    typedef struct {
        logic [6:0] a7;
        logic [7:0] b0, b1, b2;
        int         nb;
        logic       exp_ack;
        logic [3:0] ia;
        logic [7:0] va;
        logic [3:0] ib;
        logic [7:0] vb;
    } vec_t;
    vec_t tbl [6];

    // Bus monitor: write pulses, SDA activity, SDA changes while SCL high.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_valid === 1'b1) act_q.push_back({wr_addr, wr_data});
        if (sda_oe === 1'b1) oe_hi_cnt <= oe_hi_cnt + 1;
        if (rst_n === 1'b1 && sda_oe !== prev_oe && scl_c === 1'b1) glitches <= glitches + 1;
        prev_oe <= sda_oe;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
    endtask

    task automatic bit_io(input logic b, output logic r);
        sda_c = b;
        #Q; scl_c = 1'b1;
        #Q; r = sda_bus;
        #Q; scl_c = 1'b0;
        #Q;
    endtask

    task automatic bus_start();
        sda_c = 1'b1;
        #Q; scl_c = 1'b1;
        #Q; sda_c = 1'b0;
        #Q; scl_c = 1'b0;
        #Q;
    endtask

    task automatic bus_stop();
        sda_c = 1'b0;
        #Q; scl_c = 1'b1;
        #Q; sda_c = 1'b1;
        #Q;
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_io(b[i], r);
        bit_io(1'b1, r);
        ack = ~r;
    endtask

    task automatic rd_byte(input logic give_ack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, r);
            d[i] = r;
        end
        bit_io(~give_ack, r);
    endtask

    task automatic peek(input int i, output logic [7:0] v);
        bk_addr = 4'(i);
        #10;
        v = bk_data;
    endtask

    task automatic check_events();
        chk("wr_count", act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            chk("wr_event", act_q[i], exp_q[i]);
        act_q.delete();
        exp_q.delete();
    endtask

    // Write transaction: tx_buf[0] is the pointer, the rest are data.
    task automatic run_write(input logic [6:0] a7, input int nb, input logic exp_ack);
        logic ack;
        logic match;
        match = (a7 == TA);
        bus_start();
        wr_byte({a7, 1'b0}, ack);
        chk("wr_addr_ack", ack, exp_ack);
        for (int i = 0; i < nb; i++) begin
            wr_byte(tx_buf[i], ack);
            chk("wr_byte_ack", ack, exp_ack);
            if (match) begin
                if (i == 0) begin
                    m_ptr = int'(tx_buf[0]) % 16;
                end else begin
                    m_regs[m_ptr] = tx_buf[i];
                    exp_q.push_back({4'(m_ptr), tx_buf[i]});
                    m_ptr = (m_ptr + 1) % 16;
                end
            end
        end
        bus_stop();
        check_events();
    endtask

    // Read transaction, optionally preceded by a pointer write and a
    // repeated START. The last byte is NACKed.
    task automatic run_read(input logic [6:0] a7, input int nr, input logic set_ptr,
                            input logic [7:0] pb);
        logic       ack;
        logic       match;
        logic [7:0] d, e;
        match = (a7 == TA);
        if (set_ptr) begin
            bus_start();
            wr_byte({TA, 1'b0}, ack);
            chk("rr_addr_ack", ack, 1'b1);
            wr_byte(pb, ack);
            chk("rr_ptr_ack", ack, 1'b1);
            m_ptr = int'(pb) % 16;
        end
        bus_start();
        wr_byte({a7, 1'b1}, ack);
        chk("rd_addr_ack", ack, match);
        for (int i = 0; i < nr; i++) begin
            rd_byte(i != nr - 1, d);
            e = match ? m_regs[m_ptr] : 8'hFF;
            chk("rd_data", d, e);
            if (match) m_ptr = (m_ptr + 1) % 16;
        end
        chk("rd_release", sda_oe, 1'b0);
        bus_stop();
        check_events();
    endtask

    initial begin
        logic [7:0] v;
        logic       ack, r;
        int         oe0, kind, n;
        logic [6:0] a7;

        tbl[0] = '{7'h50, 8'h03, 8'h5A, 8'hC3, 3, 1'b1, 4'h3, 8'h5A, 4'h4, 8'hC3};
        tbl[1] = '{7'h50, 8'h0F, 8'h11, 8'h22, 3, 1'b1, 4'hF, 8'h11, 4'h0, 8'h22};
        tbl[2] = '{7'h51, 8'h00, 8'h00, 8'h00, 1, 1'b0, 4'h0, 8'h22, 4'h3, 8'h5A};
        tbl[3] = '{7'h50, 8'hF2, 8'h77, 8'h00, 2, 1'b1, 4'h2, 8'h77, 4'h3, 8'h5A};
        tbl[4] = '{7'h50, 8'h05, 8'h6B, 8'h00, 2, 1'b1, 4'h5, 8'h6B, 4'h6, 8'h00};
        tbl[5] = '{7'h00, 8'h05, 8'h99, 8'h00, 2, 1'b0, 4'h5, 8'h6B, 4'h0, 8'h22};

        rst_n   = 1'b0;
        scl_c   = 1'b1;
        sda_c   = 1'b1;
        bk_addr = 4'h0;
        model_reset();

        #20;
        chk("rst_sda_oe", sda_oe, 1'b0);
        chk("rst_wr_valid", wr_valid, 1'b0);
        chk("rst_wr_addr", wr_addr, 4'h0);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_reg0", bk_data, 8'h00);
        #80;
        rst_n = 1'b1;
        #100;

        // Directed transactions from the table.
        for (int i = 0; i < 6; i++) begin
            oe0 = oe_hi_cnt;
            tx_buf[0] = tbl[i].b0;
            tx_buf[1] = tbl[i].b1;
            tx_buf[2] = tbl[i].b2;
            run_write(tbl[i].a7, tbl[i].nb, tbl[i].exp_ack);
            if (!tbl[i].exp_ack) chk("nomatch_sda_quiet", oe_hi_cnt - oe0, 0);
            peek(int'(tbl[i].ia), v);
            chk("tbl_reg_a", v, tbl[i].va);
            peek(int'(tbl[i].ib), v);
            chk("tbl_reg_b", v, tbl[i].vb);
        end

        // Random read from index 3, then a current-address read that
        // must land on index 5.
        run_read(TA, 2, 1'b1, 8'h03);
        run_read(TA, 1, 1'b0, 8'h00);

        // Abort: STOP after four bits of a data byte.
        bus_start();
        wr_byte({TA, 1'b0}, ack);
        chk("abort_addr_ack", ack, 1'b1);
        wr_byte(8'h07, ack);
        chk("abort_ptr_ack", ack, 1'b1);
        m_ptr = 7;
        for (int i = 0; i < 4; i++) bit_io(1'b1, r);
        bus_stop();
        chk("abort_sda_oe", sda_oe, 1'b0);
        check_events();
        peek(7, v);
        chk("abort_reg7", v, m_regs[7]);

        // With no START the device must ignore a full address byte.
        scl_c = 1'b0;
        #Q;
        wr_byte({TA, 1'b0}, ack);
        chk("idle_ignore", ack, 1'b0);
        bus_stop();
        check_events();

        // Reset while the device is driving bit 7 (a 0) of regs[3].
        bus_start();
        wr_byte({TA, 1'b0}, ack);
        wr_byte(8'h03, ack);
        bus_start();
        wr_byte({TA, 1'b1}, ack);
        chk("rst_rd_addr_ack", ack, 1'b1);
        sda_c = 1'b1;
        #Q; scl_c = 1'b1;
        #20;
        chk("rst_rd_bit7_driven", sda_oe, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_release", sda_oe, 1'b0);
        #29;
        #50;
        rst_n = 1'b1;
        model_reset();
        act_q.delete();
        #50;
        for (int i = 0; i < 16; i++) begin
            peek(i, v);
            chk("rst_regs_clear", v, 8'h00);
        end
        scl_c = 1'b0;
        #Q;
        bus_stop();

        // Randomised transactions against the model.
        for (int t = 0; t < 25; t++) begin
            kind = int'($urandom_range(0, 2));
            a7   = TA;
            if ($urandom_range(0, 4) == 0) begin
                a7 = 7'($urandom_range(0, 127));
                if (a7 == TA) a7 = 7'h51;
            end
            if (kind == 0) begin
                n = int'($urandom_range(1, 5));
                for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom());
                run_write(a7, n, a7 == TA);
            end else if (kind == 1) begin
                run_read(a7, int'($urandom_range(1, 4)), 1'b1, 8'($urandom()));
            end else begin
                run_read(a7, int'($urandom_range(1, 3)), 1'b0, 8'h00);
            end
        end

        for (int i = 0; i < 16; i++) begin
            peek(i, v);
            chk("final_reg", v, m_regs[i]);
        end
        chk("sda_change_scl_high", glitches, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
